// File: rtl/ddr_ring_controller_if.sv
// Buffer and memory-port signal bundle for ddr_ring_controller.
// The controller connects through the master modport; buffers and the memory port sit on the slave side.
interface ddr_ring_controller_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
);
    logic                  ib_re;
    logic [DATA_W-1:0]     ib_data;
    logic [CNT_W-1:0]      ib_count;
    logic                  ib_valid;
    logic                  ob_we;
    logic [DATA_W-1:0]     ob_data;
    logic [CNT_W-1:0]      ob_count;
    logic                  p0_cmd_full;
    logic                  p0_cmd_en;
    logic [2:0]            p0_cmd_instr;
    logic [29:0]           p0_cmd_byte_addr;
    logic [5:0]            p0_cmd_bl_o;
    logic                  p0_wr_full;
    logic                  p0_wr_en;
    logic [DATA_W-1:0]     p0_wr_data;
    logic [DATA_W/8-1:0]   p0_wr_mask;
    logic                  p0_rd_empty;
    logic                  p0_rd_en_o;
    logic [DATA_W-1:0]     p0_rd_data;

    modport master (
        output ib_re, ob_we, ob_data,
        output p0_cmd_en, p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl_o,
        output p0_wr_en, p0_wr_data, p0_wr_mask, p0_rd_en_o,
        input  ib_data, ib_count, ib_valid, ob_count,
        input  p0_cmd_full, p0_wr_full, p0_rd_empty, p0_rd_data
    );

    modport slave (
        input  ib_re, ob_we, ob_data,
        input  p0_cmd_en, p0_cmd_instr, p0_cmd_byte_addr, p0_cmd_bl_o,
        input  p0_wr_en, p0_wr_data, p0_wr_mask, p0_rd_en_o,
        output ib_data, ib_count, ib_valid, ob_count,
        output p0_cmd_full, p0_wr_full, p0_rd_empty, p0_rd_data
    );
endinterface

// File: rtl/ddr_ring_controller.sv
// Streams input-buffer words into an SDRAM ring in fixed bursts and drains them back out,
// alternating write and read bursts when both are possible.
module ddr_ring_controller #(
    parameter int DATA_W     = 32,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 1024,
    parameter int CNT_W      = 10,
    parameter int ADDR_BASE  = 0,
    parameter int RING_BYTES = 2**26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        writes_en,
    input  logic        reads_en,
    input  logic        calib_done,
    input  logic        flush,
    ddr_ring_controller_if.master bus,
    output logic [29:0] cmd_byte_addr_wr,
    output logic [29:0] cmd_byte_addr_rd,
    output logic [29:0] occupancy,
    output logic        ring_full
);
    localparam int               BURST_BYTES = BURST_LEN * DATA_W / 8;
    localparam logic [29:0]      BB          = 30'(BURST_BYTES);
    localparam logic [29:0]      RING_MASK   = 30'(RING_BYTES - 1);
    localparam logic [29:0]      FULL_TH     = 30'(RING_BYTES - BURST_BYTES);
    localparam logic [29:0]      BASE        = 30'(ADDR_BASE);
    localparam logic [CNT_W-1:0] WR_MIN      = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] RD_MAX      = CNT_W'(FIFO_DEPTH - 1 - BURST_LEN);
    localparam logic [6:0]       CNT_INIT    = 7'(BURST_LEN);

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_DATA, WR_PUSH, WR_CMD, RD_CMD, RD_WAIT, RD_DATA
    } state_t;

    state_t              state_q, state_d;
    logic                wr_mode_p0, rd_mode_p0;
    logic                last_wr_q, last_wr_d;
    logic                flush_pend_q;
    logic [6:0]          cnt_q;
    logic [29:0]         wr_off_q, rd_off_q, occ_q;
    logic                ib_re_q, ob_we_q, cmd_en_q, wr_en_q, rd_en_q;
    logic                ib_re_d, ob_we_d, cmd_en_d, wr_en_d, rd_en_d;
    logic [2:0]          cmd_instr_q;
    logic [29:0]         cmd_addr_q;
    logic [DATA_W-1:0]   wr_data_q, ob_data_q;
    logic                wr_adv, rd_adv, do_flush, cnt_load, cnt_dec, cap_wr, cap_rd;
    logic                wr_elig, rd_elig;

    assign cmd_byte_addr_wr = BASE + wr_off_q;
    assign cmd_byte_addr_rd = BASE + rd_off_q;
    assign occupancy        = occ_q;
    assign ring_full        = (occ_q > FULL_TH);

    assign wr_elig = calib_done && wr_mode_p0 && (bus.ib_count >= WR_MIN) && !ring_full;
    assign rd_elig = calib_done && rd_mode_p0 && (bus.ob_count <= RD_MAX) && (occ_q >= BB);

    assign bus.ib_re            = ib_re_q;
    assign bus.ob_we            = ob_we_q;
    assign bus.ob_data          = ob_data_q;
    assign bus.p0_cmd_en        = cmd_en_q;
    assign bus.p0_cmd_instr     = cmd_instr_q;
    assign bus.p0_cmd_byte_addr = cmd_addr_q;
    assign bus.p0_cmd_bl_o      = 6'(BURST_LEN - 1);
    assign bus.p0_wr_en         = wr_en_q;
    assign bus.p0_wr_data       = wr_data_q;
    assign bus.p0_wr_mask       = '0;
    assign bus.p0_rd_en_o       = rd_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Strobes are decided here one cycle ahead and registered below.
    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        ib_re_d   = 1'b0;
        ob_we_d   = 1'b0;
        cmd_en_d  = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        wr_adv    = 1'b0;
        rd_adv    = 1'b0;
        do_flush  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cap_wr    = 1'b0;
        cap_rd    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_load = 1'b1;
                if (flush || flush_pend_q) begin
                    do_flush = 1'b1;
                end else if (wr_elig && (!rd_elig || !last_wr_q)) begin
                    state_d   = WR_REQ;
                    last_wr_d = 1'b1;
                end else if (rd_elig) begin
                    state_d   = RD_CMD;
                    last_wr_d = 1'b0;
                end
            end
            WR_REQ: begin
                ib_re_d = 1'b1;
                state_d = WR_DATA;
            end
            WR_DATA: if (bus.ib_valid) begin
                cap_wr  = 1'b1;
                state_d = WR_PUSH;
            end
            WR_PUSH: if (!bus.p0_wr_full) begin
                wr_en_d = 1'b1;
                cnt_dec = 1'b1;
                state_d = (cnt_q == 7'd1) ? WR_CMD : WR_REQ;
            end
            WR_CMD: if (!bus.p0_cmd_full) begin
                cmd_en_d = 1'b1;
                wr_adv   = 1'b1;
                state_d  = IDLE;
            end
            RD_CMD: if (!bus.p0_cmd_full) begin
                cmd_en_d = 1'b1;
                rd_adv   = 1'b1;
                state_d  = RD_WAIT;
            end
            RD_WAIT: if (!bus.p0_rd_empty) begin
                rd_en_d = 1'b1;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                cap_rd  = 1'b1;
                ob_we_d = 1'b1;
                cnt_dec = 1'b1;
                state_d = (cnt_q == 7'd1) ? IDLE : RD_WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_mode_p0   <= 1'b0;
            rd_mode_p0   <= 1'b0;
            last_wr_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            wr_off_q     <= '0;
            rd_off_q     <= '0;
            occ_q        <= '0;
            ib_re_q      <= 1'b0;
            ob_we_q      <= 1'b0;
            cmd_en_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            cmd_instr_q  <= '0;
            cmd_addr_q   <= '0;
            wr_data_q    <= '0;
            ob_data_q    <= '0;
        end else begin
            wr_mode_p0 <= writes_en;
            rd_mode_p0 <= reads_en;
            last_wr_q  <= last_wr_d;
            ib_re_q    <= ib_re_d;
            ob_we_q    <= ob_we_d;
            cmd_en_q   <= cmd_en_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            if (cnt_load)     cnt_q <= CNT_INIT;
            else if (cnt_dec) cnt_q <= cnt_q - 7'd1;
            // A flush seen mid-burst is held until the controller is back in IDLE.
            if (do_flush)   flush_pend_q <= 1'b0;
            else if (flush) flush_pend_q <= 1'b1;
            if (do_flush) begin
                wr_off_q <= '0;
                rd_off_q <= '0;
                occ_q    <= '0;
            end else if (wr_adv) begin
                wr_off_q <= (wr_off_q + BB) & RING_MASK;
                occ_q    <= occ_q + BB;
            end else if (rd_adv) begin
                rd_off_q <= (rd_off_q + BB) & RING_MASK;
                occ_q    <= occ_q - BB;
            end
            if (cmd_en_d) begin
                cmd_instr_q <= wr_adv ? 3'b000 : 3'b001;
                cmd_addr_q  <= wr_adv ? cmd_byte_addr_wr : cmd_byte_addr_rd;
            end
            if (cap_wr) wr_data_q <= bus.ib_data;
            if (cap_rd) ob_data_q <= bus.p0_rd_data;
        end
    end
endmodule

// File: tb/tb_ddr_ring_controller.sv
// Directed bench for ddr_ring_controller with a 64-byte ring (BURST_LEN 4, 32-bit words).
module tb_ddr_ring_controller;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 10;
    localparam int RING   = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        writes_en = 1'b0, reads_en = 1'b0, calib_done = 1'b0, flush = 1'b0;
    logic [29:0] addr_wr, addr_rd, occ;
    logic        ring_full;
    logic [31:0] ib_word = 32'h100;
    logic [31:0] rd_word = 32'h200;
    int          n_tests = 0, n_fail = 0;
    int          n_ib_re = 0, n_rd_en = 0;
    logic [31:0] wr_log[$];
    logic [31:0] ob_log[$];
    logic [2:0]  cmd_instr_log[$];
    logic [29:0] cmd_addr_log[$];

    ddr_ring_controller_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

    ddr_ring_controller #(
        .DATA_W(DATA_W), .BURST_LEN(4), .FIFO_DEPTH(1024), .CNT_W(CNT_W),
        .ADDR_BASE(0), .RING_BYTES(RING)
    ) dut (
        .clk(clk), .reset(reset), .writes_en(writes_en), .reads_en(reads_en),
        .calib_done(calib_done), .flush(flush), .bus(bus),
        .cmd_byte_addr_wr(addr_wr), .cmd_byte_addr_rd(addr_rd),
        .occupancy(occ), .ring_full(ring_full)
    );

    always #5 clk = ~clk;

    assign bus.ib_data    = ib_word;
    assign bus.p0_rd_data = rd_word;

    // First-word-fall-through buffers: a read strobe pops and exposes the next word.
    always @(negedge clk) begin
        if (bus.ib_re) begin ib_word = ib_word + 1; n_ib_re++; end
        if (bus.p0_rd_en_o) begin rd_word = rd_word + 1; n_rd_en++; end
        if (bus.p0_wr_en) wr_log.push_back(bus.p0_wr_data);
        if (bus.ob_we) ob_log.push_back(bus.ob_data);
        if (bus.p0_cmd_en) begin
            cmd_instr_log.push_back(bus.p0_cmd_instr);
            cmd_addr_log.push_back(bus.p0_cmd_byte_addr);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        writes_en = 1'b0; reads_en = 1'b0; flush = 1'b0;
        bus.ib_count = '0; bus.ib_valid = 1'b1; bus.ob_count = '0;
        bus.p0_cmd_full = 1'b0; bus.p0_wr_full = 1'b0; bus.p0_rd_empty = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.ib_count = '0; bus.ib_valid = 1'b1; bus.ob_count = '0;
        bus.p0_cmd_full = 1'b0; bus.p0_wr_full = 1'b0; bus.p0_rd_empty = 1'b1;
        repeat (2) tick();
        n_tests++; if ({bus.ib_re, bus.ob_we, bus.p0_cmd_en, bus.p0_wr_en, bus.p0_rd_en_o} !== 5'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 00000", {bus.ib_re, bus.ob_we, bus.p0_cmd_en, bus.p0_wr_en, bus.p0_rd_en_o}); end
        n_tests++; if (occ !== 30'd0 || ring_full !== 1'b0) begin n_fail++; $display("FAIL reset_occ: got %0d/%b want 0/0", occ, ring_full); end
        n_tests++; if (addr_wr !== 30'd0 || addr_rd !== 30'd0) begin n_fail++; $display("FAIL reset_ptrs: got %0h/%0h want 0/0", addr_wr, addr_rd); end
        n_tests++; if (bus.p0_cmd_instr !== 3'd0 || bus.p0_cmd_byte_addr !== 30'd0) begin n_fail++; $display("FAIL reset_cmd: got %0h/%0h want 0/0", bus.p0_cmd_instr, bus.p0_cmd_byte_addr); end
        n_tests++; if (bus.ob_data !== 32'd0 || bus.p0_wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %0h/%0h want 0/0", bus.ob_data, bus.p0_wr_data); end
        n_tests++; if (bus.p0_cmd_bl_o !== 6'd3 || bus.p0_wr_mask !== 4'd0) begin n_fail++; $display("FAIL reset_consts: got %0d/%0h want 3/0", bus.p0_cmd_bl_o, bus.p0_wr_mask); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        int c0, w0, r0, cyc;
        logic [31:0] ib0;
        do_reset();
        calib_done = 1'b1; bus.ib_count = 10'd4;
        c0 = cmd_addr_log.size(); w0 = wr_log.size(); r0 = n_ib_re; ib0 = ib_word;
        writes_en = 1'b1;
        cyc = 0;
        while (n_ib_re == r0 && cyc < 50) begin tick(); cyc++; end
        writes_en = 1'b0;
        while (cmd_addr_log.size() < c0 + 1 && cyc < 200) begin tick(); cyc++; end
        repeat (5) tick();
        n_tests++; if (cmd_addr_log.size() != c0 + 1) begin n_fail++; $display("FAIL single_cmd_count: got %0d want %0d", cmd_addr_log.size() - c0, 1); end
        n_tests++; if (n_ib_re - r0 != 4 || wr_log.size() - w0 != 4) begin n_fail++; $display("FAIL single_pairs: got %0d ib_re/%0d wr_en want 4/4", n_ib_re - r0, wr_log.size() - w0); end
        if (cmd_addr_log.size() > c0) begin
            n_tests++; if (cmd_instr_log[c0] !== 3'd0 || cmd_addr_log[c0] !== 30'h0) begin n_fail++; $display("FAIL single_cmd: got %0d@%0h want 0@0", cmd_instr_log[c0], cmd_addr_log[c0]); end
        end
        if (wr_log.size() >= w0 + 4) begin
            n_tests++; if (wr_log[w0] !== ib0 + 1 || wr_log[w0+3] !== ib0 + 4) begin n_fail++; $display("FAIL single_wdata: got %0h..%0h want %0h..%0h", wr_log[w0], wr_log[w0+3], ib0 + 1, ib0 + 4); end
        end
        n_tests++; if (occ !== 30'd16) begin n_fail++; $display("FAIL single_occ: got %0d want 16", occ); end
        n_tests++; if (addr_wr !== 30'h10 || addr_rd !== 30'h0) begin n_fail++; $display("FAIL single_ptrs: got %0h/%0h want 10/0", addr_wr, addr_rd); end
    endtask

    task automatic test_alternate();
        int c0, rd0, cyc;
        do_reset();
        bus.ib_count = 10'd4; bus.p0_rd_empty = 1'b0;
        reads_en = 1'b1;
        c0 = cmd_addr_log.size(); rd0 = n_rd_en;
        repeat (20) tick();
        n_tests++; if (cmd_addr_log.size() != c0 || n_rd_en != rd0) begin n_fail++; $display("FAIL alt_no_read_empty: got %0d cmds want 0", cmd_addr_log.size() - c0); end
        writes_en = 1'b1;
        cyc = 0;
        while (cmd_addr_log.size() < c0 + 6 && cyc < 600) begin tick(); cyc++; end
        writes_en = 1'b0; reads_en = 1'b0;
        n_tests++; if (cmd_addr_log.size() < c0 + 6) begin n_fail++; $display("FAIL alt_timeout: got %0d cmds want 6", cmd_addr_log.size() - c0); end
        for (int i = 0; i < 6 && c0 + i < cmd_addr_log.size(); i++) begin
            n_tests++;
            if (cmd_instr_log[c0+i] !== 3'(i % 2) || cmd_addr_log[c0+i] !== 30'((i / 2) * 16)) begin
                n_fail++; $display("FAIL alt_cmd%0d: got %0d@%0h want %0d@%0h", i, cmd_instr_log[c0+i], cmd_addr_log[c0+i], i % 2, (i / 2) * 16);
            end
        end
        repeat (80) tick();
    endtask

    task automatic test_wrap_full();
        int c0, o0, r0, cyc;
        logic [31:0] rd0;
        do_reset();
        bus.ib_count = 10'd4;
        c0 = cmd_addr_log.size(); r0 = n_ib_re;
        writes_en = 1'b1;
        cyc = 0;
        while (cmd_addr_log.size() < c0 + 4 && cyc < 400) begin tick(); cyc++; end
        n_tests++; if (cmd_addr_log.size() < c0 + 4) begin n_fail++; $display("FAIL wrap_timeout: got %0d cmds want 4", cmd_addr_log.size() - c0); end
        for (int i = 0; i < 4 && c0 + i < cmd_addr_log.size(); i++) begin
            n_tests++;
            if (cmd_instr_log[c0+i] !== 3'd0 || cmd_addr_log[c0+i] !== 30'(i * 16)) begin
                n_fail++; $display("FAIL wrap_wr%0d: got %0d@%0h want 0@%0h", i, cmd_instr_log[c0+i], cmd_addr_log[c0+i], i * 16);
            end
        end
        n_tests++; if (occ !== 30'd64 || ring_full !== 1'b1) begin n_fail++; $display("FAIL wrap_full: got %0d/%b want 64/1", occ, ring_full); end
        n_tests++; if (addr_wr !== 30'h0) begin n_fail++; $display("FAIL wrap_ptr: got %0h want 0", addr_wr); end
        repeat (40) tick();
        n_tests++; if (cmd_addr_log.size() != c0 + 4 || n_ib_re - r0 != 16) begin n_fail++; $display("FAIL wrap_stop: got %0d cmds/%0d ib_re want 4/16", cmd_addr_log.size() - c0, n_ib_re - r0); end
        o0 = ob_log.size(); rd0 = rd_word;
        bus.p0_rd_empty = 1'b0; reads_en = 1'b1;
        cyc = 0;
        while (cmd_addr_log.size() < c0 + 6 && cyc < 300) begin tick(); cyc++; end
        writes_en = 1'b0; reads_en = 1'b0;
        n_tests++; if (cmd_addr_log.size() < c0 + 6) begin n_fail++; $display("FAIL wrap_resume: got %0d cmds want 6", cmd_addr_log.size() - c0); end
        if (cmd_addr_log.size() >= c0 + 6) begin
            n_tests++; if (cmd_instr_log[c0+4] !== 3'd1 || cmd_addr_log[c0+4] !== 30'h0) begin n_fail++; $display("FAIL wrap_rd0: got %0d@%0h want 1@0", cmd_instr_log[c0+4], cmd_addr_log[c0+4]); end
            n_tests++; if (cmd_instr_log[c0+5] !== 3'd0 || cmd_addr_log[c0+5] !== 30'h0) begin n_fail++; $display("FAIL wrap_wr4: got %0d@%0h want 0@0", cmd_instr_log[c0+5], cmd_addr_log[c0+5]); end
        end
        if (ob_log.size() > o0) begin
            n_tests++; if (ob_log[o0] !== rd0 + 1) begin n_fail++; $display("FAIL wrap_rdata: got %0h want %0h", ob_log[o0], rd0 + 1); end
        end
        repeat (80) tick();
    endtask

    task automatic test_cmd_full_hold();
        int c0, w0, r0, cyc, seen;
        do_reset();
        bus.ib_count = 10'd4; bus.p0_cmd_full = 1'b1;
        c0 = cmd_addr_log.size(); w0 = wr_log.size(); r0 = n_ib_re;
        writes_en = 1'b1;
        cyc = 0;
        while (n_ib_re == r0 && cyc < 50) begin tick(); cyc++; end
        writes_en = 1'b0;
        while (wr_log.size() < w0 + 4 && cyc < 200) begin tick(); cyc++; end
        seen = 0;
        repeat (10) begin tick(); if (bus.p0_cmd_en) seen++; end
        n_tests++; if (seen != 0 || cmd_addr_log.size() != c0) begin n_fail++; $display("FAIL hold_no_cmd: got %0d strobes want 0", seen); end
        bus.p0_cmd_full = 1'b0;
        tick();
        n_tests++; if (bus.p0_cmd_en !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %b want 1", bus.p0_cmd_en); end
        tick();
        n_tests++; if (bus.p0_cmd_en !== 1'b0 || cmd_addr_log.size() != c0 + 1) begin n_fail++; $display("FAIL hold_single: got %0d cmds want 1", cmd_addr_log.size() - c0); end
    endtask

    task automatic test_flush();
        int c0, o0, r0, cyc;
        do_reset();
        bus.ib_count = 10'd4;
        c0 = cmd_addr_log.size(); r0 = n_ib_re;
        writes_en = 1'b1;
        cyc = 0;
        while (n_ib_re < r0 + 5 && cyc < 200) begin tick(); cyc++; end
        writes_en = 1'b0;
        while (cmd_addr_log.size() < c0 + 2 && cyc < 300) begin tick(); cyc++; end
        repeat (5) tick();
        reads_en = 1'b1;
        while (cmd_addr_log.size() < c0 + 3 && cyc < 400) begin tick(); cyc++; end
        reads_en = 1'b0;
        n_tests++; if (occ !== 30'd16 || addr_rd !== 30'h10) begin n_fail++; $display("FAIL flush_pre: got %0d/%0h want 16/10", occ, addr_rd); end
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (3) tick();
        n_tests++; if (occ !== 30'd16 || addr_wr !== 30'h20) begin n_fail++; $display("FAIL flush_deferred: got %0d/%0h want 16/20", occ, addr_wr); end
        o0 = ob_log.size();
        bus.p0_rd_empty = 1'b0;
        cyc = 0;
        while (ob_log.size() < o0 + 4 && cyc < 100) begin tick(); cyc++; end
        repeat (3) tick();
        n_tests++; if (ob_log.size() != o0 + 4) begin n_fail++; $display("FAIL flush_burst_done: got %0d ob_we want 4", ob_log.size() - o0); end
        n_tests++; if (occ !== 30'd0 || addr_wr !== 30'h0 || addr_rd !== 30'h0) begin n_fail++; $display("FAIL flush_state: got %0d/%0h/%0h want 0/0/0", occ, addr_wr, addr_rd); end
        n_tests++; if (cmd_addr_log.size() != c0 + 3) begin n_fail++; $display("FAIL flush_no_new: got %0d cmds want 3", cmd_addr_log.size() - c0); end
    endtask

    task automatic test_reset_mid_burst();
        int r0, r1, cyc, seen;
        do_reset();
        bus.ib_count = 10'd4; bus.p0_wr_full = 1'b1;
        r0 = n_ib_re;
        writes_en = 1'b1;
        cyc = 0;
        while (n_ib_re == r0 && cyc < 50) begin tick(); cyc++; end
        repeat (3) tick();
        n_tests++; if (bus.p0_wr_data !== ib_word || bus.p0_wr_en !== 1'b0) begin n_fail++; $display("FAIL midrst_stall: got %0h/%b want %0h/0", bus.p0_wr_data, bus.p0_wr_en, ib_word); end
        #2 reset = 1'b0;
        #1;
        n_tests++; if ({bus.ib_re, bus.ob_we, bus.p0_cmd_en, bus.p0_wr_en, bus.p0_rd_en_o} !== 5'b0 || bus.p0_wr_data !== 32'd0) begin n_fail++; $display("FAIL midrst_async: got %b/%0h want 00000/0", {bus.ib_re, bus.ob_we, bus.p0_cmd_en, bus.p0_wr_en, bus.p0_rd_en_o}, bus.p0_wr_data); end
        n_tests++; if (occ !== 30'd0 || addr_wr !== 30'd0) begin n_fail++; $display("FAIL midrst_regs: got %0d/%0h want 0/0", occ, addr_wr); end
        bus.p0_wr_full = 1'b0;
        tick();
        reset = 1'b1;
        r1 = n_ib_re; seen = 0;
        repeat (2) begin tick(); if ({bus.ib_re, bus.ob_we, bus.p0_cmd_en, bus.p0_wr_en, bus.p0_rd_en_o} != 5'b0) seen++; end
        n_tests++; if (seen != 0 || n_ib_re != r1) begin n_fail++; $display("FAIL midrst_quiet: got %0d strobe cycles want 0", seen); end
        cyc = 0;
        while (n_ib_re == r1 && cyc < 50) begin tick(); cyc++; end
        n_tests++; if (n_ib_re == r1) begin n_fail++; $display("FAIL midrst_resume: got 0 ib_re want >0"); end
        writes_en = 1'b0;
        repeat (60) tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_alternate();
        test_wrap_full();
        test_cmd_full_hold();
        test_flush();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr_ring_controller.md
DDR_RING_CONTROLLER -- requirements
Module: ddr_ring_controller

Interface
REQ-001 SHALL provide parameter DATA_W, 32, port data width in bits (32 or 64).
REQ-002 SHALL provide parameter BURST_LEN, 4, words per SDRAM burst (even, 2..64).
REQ-003 SHALL provide parameter FIFO_DEPTH, 1024, depth of the external input and output buffers.
REQ-004 SHALL provide parameter CNT_W, 10, width of the buffer count inputs.
REQ-005 SHALL provide parameter ADDR_BASE, 0, byte address of ring start (multiple of BURST_BYTES).
REQ-006 SHALL provide parameter RING_BYTES, 2^26, ring size in bytes (power of two, at least 2*BURST_BYTES); BURST_BYTES = BURST_LEN*DATA_W/8.
REQ-007 Ports SHALL be:
  clk  in  1  sole clock, all logic on rising edge
  reset  in  1  asynchronous, active-low reset
  writes_en / reads_en  in  1  each  write/read mode enables, registered once internally
  calib_done  in  1  memory calibration complete
  flush  in  1  request to empty the ring
  ib_re  out  1  input-buffer read pulse
  ib_data  in  DATA_W  input-buffer data
  ib_count  in  CNT_W  input-buffer fill level
  ib_valid  in  1  ib_data valid
  ob_we  out  1  output-buffer write pulse
  ob_data  out  DATA_W  output-buffer data
  ob_count  in  CNT_W  output-buffer fill level
  p0_cmd_full  in  1  command FIFO full
  p0_cmd_en  out  1  command strobe
  p0_cmd_instr  out  3  000 = write, 001 = read
  p0_cmd_byte_addr  out  30  burst byte address
  p0_cmd_bl_o  out  6  constant BURST_LEN-1
  p0_wr_full  in  1  write-data FIFO full
  p0_wr_en  out  1  write-data strobe
  p0_wr_data  out  DATA_W  write data
  p0_wr_mask  out  DATA_W/8  constant all zero
  p0_rd_empty  in  1  read-data FIFO empty
  p0_rd_en_o  out  1  read-data strobe
  p0_rd_data  in  DATA_W  read data
  cmd_byte_addr_wr / cmd_byte_addr_rd  out  30 each  next absolute write/read address
  occupancy  out  30  bytes written but not yet read
  ring_full  out  1  occupancy > RING_BYTES-BURST_BYTES

Function
REQ-008 All strobes (ib_re, ob_we, p0_cmd_en, p0_wr_en, p0_rd_en_o) SHALL be registered single-cycle pulses, low by default.
REQ-009 Write eligibility SHALL be: calib_done, write mode, ib_count>=BURST_LEN, ring_full=0.
REQ-010 Read eligibility SHALL be: calib_done, read mode, ob_count<=FIFO_DEPTH-1-BURST_LEN, occupancy>=BURST_BYTES.
REQ-011 In IDLE, when both are eligible, the controller SHALL select the operation not selected last (round-robin); last-op flag resets to "read".
REQ-012 IDLE SHALL load burst counter = BURST_LEN.
REQ-013 Write path: WR_REQ pulses ib_re -> WR_DATA; WR_DATA waits for ib_valid and captures ib_data into p0_wr_data -> WR_PUSH; WR_PUSH pulses p0_wr_en only when p0_wr_full=0 and decrements the counter, then goes to WR_CMD if the counter reaches 0, otherwise to WR_REQ.
REQ-014 WR_CMD SHALL wait while p0_cmd_full=1, then pulse p0_cmd_en with instr 000 and address cmd_byte_addr_wr, advance the write pointer, add BURST_BYTES to occupancy, and return to IDLE.
REQ-015 Read path: RD_CMD waits while p0_cmd_full=1, then pulses p0_cmd_en with instr 001 and address cmd_byte_addr_rd, advances the read pointer, subtracts BURST_BYTES from occupancy -> RD_WAIT.
REQ-016 RD_WAIT SHALL pulse p0_rd_en_o when p0_rd_empty=0 -> RD_DATA; RD_DATA SHALL latch p0_rd_data into ob_data, pulse ob_we, decrement the counter, then go to IDLE at 0, otherwise to RD_WAIT.
REQ-017 Pointer advance SHALL be ADDR_BASE + ((offset + BURST_BYTES) mod RING_BYTES); wrap SHALL be exact, with no skipped or repeated burst.
REQ-018 Occupancy SHALL never exceed RING_BYTES or go below 0; write and read updates never coincide.
REQ-019 flush SHALL be acted on only in IDLE and SHALL take priority over new bursts: both pointers return to ADDR_BASE and occupancy to 0 in one cycle; a burst in progress completes first.
REQ-020 Deasserting a mode enable mid-burst SHALL NOT abort the burst.

Reset
REQ-021 While reset=0: state IDLE, pointers = ADDR_BASE, occupancy 0, burst counter 0, last-op flag = read, all strobes 0, p0_cmd_instr 0, p0_cmd_byte_addr 0, ob_data 0, p0_wr_data 0.
REQ-022 Reset asserted mid-burst SHALL abandon the burst immediately; no strobe SHALL be issued in the cycle after release.

Verification
REQ-023 Defaults, write mode, ib_count=4 -> four ib_re/p0_wr_en pairs, one write command at 0x0, occupancy 16, cmd_byte_addr_wr 0x10.
REQ-024 Both modes on, sustained data -> commands alternate write/read; read addresses follow write addresses; no read issued while occupancy 0.
REQ-025 RING_BYTES=64, continuous traffic -> write addresses 0x00, 0x10, 0x20, 0x30, 0x00; with no reads, ring_full=1 at occupancy 64 and writes stop.
REQ-026 Hold p0_cmd_full=1 for 10 cycles in WR_CMD -> no p0_cmd_en during the hold; exactly one command in the cycle after release.
REQ-027 flush pulse during a read burst -> burst completes, then pointers = ADDR_BASE and occupancy 0.
REQ-028 Assert reset during WR_PUSH -> all outputs at reset values immediately; after release, one IDLE cycle precedes any strobe.
